// File: rtl/microcode_loader.sv
// Packs a byte stream (LSB first) into 64-bit microwords and writes them to the control store.
// Define MICROCODE_LOADER_VERIFY_EN to add a read-back VERIFY phase after every write.
module microcode_loader #(
  parameter int ADDR_W     = 8,
  parameter int WORD_COUNT = 256,
  parameter int W_PULSE    = 2
) (
  input  logic              clk,
  input  logic              _rst,
  input  logic              start,
  input  logic              abort,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              _cs,
  output logic              _oe,
  output logic              _w,
  output logic [ADDR_W-1:0] addr,
  output logic [63:0]       wdata,
  input  logic [63:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_SETUP   = 3'd2;
  localparam logic [2:0] S_WLOW    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;
  localparam logic [2:0] S_VERIFY  = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam int CNT_W = (W_PULSE > 1) ? $clog2(W_PULSE) : 1;
  localparam logic [CNT_W-1:0]  PULSE_LAST = CNT_W'(W_PULSE - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(WORD_COUNT - 1);

  logic [2:0]       state;
  logic [2:0]       byte_idx;
  logic [CNT_W-1:0] pulse_cnt;
  logic             abort_pend;
  logic             in_write;
  logic             word_end;

  assign dbg_state = state;
  assign in_write  = (state == S_SETUP) || (state == S_WLOW) ||
                     (state == S_HOLD)  || (state == S_VERIFY);

`ifdef MICROCODE_LOADER_VERIFY_EN
  logic verify_cnt;
  assign word_end = (state == S_VERIFY) && verify_cnt;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;
  assign word_end     = (state == S_HOLD);
  assign _oe          = 1'b1;
  assign err          = 1'b0;
  assign err_addr     = '0;
`endif

  // Byte handshake: a byte transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready is registered and only 1 in COLLECT, so the producer may hold in_valid freely.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state      <= S_IDLE;
      byte_idx   <= '0;
      pulse_cnt  <= '0;
      abort_pend <= 1'b0;
      in_ready   <= 1'b0;
      _cs        <= 1'b1;
      _w         <= 1'b1;
      addr       <= '0;
      wdata      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MICROCODE_LOADER_VERIFY_EN
      _oe        <= 1'b1;
      err        <= 1'b0;
      err_addr   <= '0;
      verify_cnt <= 1'b0;
`endif
    end else begin
      // An abort during a write is remembered so the strobe sequence is never truncated.
      if (in_write && abort) abort_pend <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (state == S_IDLE && abort) begin
            busy <= 1'b0;
            done <= 1'b0;
          end else if (start) begin
            state      <= S_COLLECT;
            addr       <= '0;
            byte_idx   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            in_ready   <= 1'b1;
            abort_pend <= 1'b0;
`ifdef MICROCODE_LOADER_VERIFY_EN
            err        <= 1'b0;
            err_addr   <= '0;
`endif
          end
        end
        S_COLLECT: begin
          if (abort) begin
            state    <= S_IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
          end else if (in_valid && in_ready) begin
            wdata[8*byte_idx +: 8] <= in_data;
            byte_idx               <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) begin
              state    <= S_SETUP;
              in_ready <= 1'b0;
              _cs      <= 1'b0;
            end
          end
        end
        S_SETUP: begin
          _w        <= 1'b0;
          pulse_cnt <= '0;
          state     <= S_WLOW;
        end
        S_WLOW: begin
          if (pulse_cnt == PULSE_LAST) begin
            _w    <= 1'b1;
            state <= S_HOLD;
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
`ifdef MICROCODE_LOADER_VERIFY_EN
        S_HOLD: begin
          _oe        <= 1'b0;
          verify_cnt <= 1'b0;
          state      <= S_VERIFY;
        end
        S_VERIFY: begin
          if (!verify_cnt) begin
            verify_cnt <= 1'b1;
          end else begin
            if (rdata != wdata) begin
              err <= 1'b1;
              if (!err) err_addr <= addr;
            end
            _oe <= 1'b1;
          end
        end
`endif
        default: ;
      endcase

      if (word_end) begin
        _cs <= 1'b1;
        if (abort_pend || abort) begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          abort_pend <= 1'b0;
        end else if (addr == LAST_ADDR) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state    <= S_COLLECT;
          addr     <= addr + ADDR_W'(1);
          byte_idx <= '0;
          in_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_microcode_loader.sv
// Bench for microcode_loader: emulates the control store, scoreboards every _w write
// and checks strobe timing, abort, reset and (with the verify macro) read-back errors.
module tb_microcode_loader;

  localparam int ADDR_W     = 8;
  localparam int WORD_COUNT = 2;
  localparam int W_PULSE    = 2;
`ifdef MICROCODE_LOADER_VERIFY_EN
  localparam int VER_CYC = 2;
`else
  localparam int VER_CYC = 0;
`endif
  localparam int CS_LOW = 1 + W_PULSE + 1 + VER_CYC;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              cs_n;
  logic              oe_n;
  logic              w_n;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       wdata;
  logic [63:0]       rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] err_addr;
  logic [2:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int w_falls = 0;
  logic [ADDR_W+63:0] exp_q[$];
  logic [63:0] mem [0:255];
  bit corrupt;

  microcode_loader #(
    .ADDR_W(ADDR_W), .WORD_COUNT(WORD_COUNT), .W_PULSE(W_PULSE)
  ) dut (
    .clk(clk), ._rst(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    ._cs(cs_n), ._oe(oe_n), ._w(w_n), .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .err(err), .err_addr(err_addr), .dbg_state(dbg_state)
  );

  // Control-store read port, with an optional single-bit fault at address 1.
  assign rdata = mem[addr] ^ ((corrupt && addr == 8'd1) ? 64'h20 : 64'h0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: the store writes on _w falling edges; every write pops the scoreboard.
  logic              p_w = 1'b1;
  logic              p_cs = 1'b1;
  int                w_low, cs_low, oe_low;
  logic [ADDR_W-1:0] h_addr;
  logic [63:0]       h_wdata;
  bit                stable_ok, ready_ok;
  logic [ADDR_W+63:0] e;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_w = 1'b1; p_cs = 1'b1; w_low = 0; cs_low = 0; oe_low = 0;
    end else begin
      if (p_cs && !cs_n) begin
        cs_low = 0; oe_low = 0; h_addr = addr; h_wdata = wdata;
        stable_ok = 1'b1; ready_ok = 1'b1;
      end
      if (!cs_n) begin
        cs_low++;
        if (!oe_n) oe_low++;
        if (addr !== h_addr || wdata !== h_wdata) stable_ok = 1'b0;
        if (in_ready !== 1'b0) ready_ok = 1'b0;
      end
      if (p_w && !w_n) begin
        w_falls++;
        w_low = 0;
        mem[addr] = wdata;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", addr, wdata);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", 72'(addr), 72'(e[ADDR_W+63:64]));
          chk("write_data", 72'(wdata), 72'(e[63:0]));
        end
      end
      if (!w_n) w_low++;
      if (!p_w && w_n) chk("w_pulse_len", 72'(w_low), 72'(W_PULSE));
      if (!p_cs && cs_n) begin
        chk("cs_low_len", 72'(cs_low), 72'(CS_LOW));
        chk("oe_low_len", 72'(oe_low), 72'(VER_CYC));
        chk("addr_wdata_stable", 72'(stable_ok), 72'(1));
        chk("in_ready_low_in_write", 72'(ready_ok), 72'(1));
      end
      p_w = w_n;
      p_cs = cs_n;
    end
  end

  task automatic start_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 72'(busy), 72'(1));
    chk("in_ready_after_start", 72'(in_ready), 72'(1));
  endtask

  // mode 0: in_valid held high, 1: toggled every cycle, 2: random gaps
  task automatic send_bytes(input logic [ADDR_W-1:0] a, input logic [63:0] word,
                            input int n, input int mode);
    bit tog;
    bit sent;
    int g;
    tog = 1'b0;
    if (n == 8) exp_q.push_back({a, word});
    for (int i = 0; i < n; i++) begin
      sent = 1'b0;
      g = 0;
      while (!sent && g < 200) begin
        @(negedge clk);
        g++;
        if ((mode == 1 && tog) || (mode == 2 && $urandom_range(0, 1) == 0)) begin
          in_valid = 1'b0;
          in_data  = 8'($urandom_range(0, 255));
        end else begin
          in_valid = 1'b1;
          in_data  = word[8*i +: 8];
          sent     = (in_ready === 1'b1);
        end
        tog = ~tog;
      end
      chk("byte_accept_timeout", 72'(sent), 72'(1));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy !== 1'b0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("idle_timeout", 72'(g < 500), 72'(1));
  endtask

  task automatic wait_w_low();
    int g;
    g = 0;
    @(negedge clk);
    while (w_n !== 1'b0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("w_low_timeout", 72'(g < 100), 72'(1));
  endtask

  task automatic run_load(input logic [63:0] w0, input logic [63:0] w1, input int mode,
                          input bit poke, input bit exp_err, input logic [ADDR_W-1:0] exp_eaddr);
    int f0;
    f0 = w_falls;
    start_load();
    if (poke) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    send_bytes(8'd0, w0, 8, mode);
    send_bytes(8'd1, w1, 8, mode);
    wait_idle();
    chk("done_after_load", 72'(done), 72'(1));
    chk("busy_after_load", 72'(busy), 72'(0));
    chk("err_after_load", 72'(err), 72'(exp_err));
    chk("err_addr_after_load", 72'(err_addr), 72'(exp_eaddr));
    chk("writes_per_load", 72'(w_falls - f0), 72'(WORD_COUNT));
    chk("mem_word0", 72'(mem[0]), 72'(w0));
    chk("mem_word1", 72'(mem[1]), 72'(w1));
  endtask

  initial begin
    int f0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00; corrupt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", 72'(cs_n), 72'(1));
    chk("rst_oe", 72'(oe_n), 72'(1));
    chk("rst_w", 72'(w_n), 72'(1));
    chk("rst_addr", 72'(addr), 72'(0));
    chk("rst_wdata", 72'(wdata), 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(0));
    chk("rst_busy", 72'(busy), 72'(0));
    chk("rst_done", 72'(done), 72'(0));
    chk("rst_err", 72'(err), 72'(0));
    chk("rst_err_addr", 72'(err_addr), 72'(0));
    rst_n = 1'b1;

    // Directed stream 0x01..0x10, then the same with in_valid toggling.
    run_load(64'h0807060504030201, 64'h100F0E0D0C0B0A09, 0, 1'b0, 1'b0, 8'd0);
    run_load(64'h0807060504030201, 64'h100F0E0D0C0B0A09, 1, 1'b0, 1'b0, 8'd0);

    // Abort after 3 bytes of word 1: only word 0 is written.
    f0 = w_falls;
    start_load();
    send_bytes(8'd0, 64'hA5A5_0000_1111_2222, 8, 0);
    send_bytes(8'd1, 64'h0BAD_0BAD_0BAD_0BAD, 3, 0);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_collect_busy", 72'(busy), 72'(0));
    chk("abort_collect_done", 72'(done), 72'(0));
    chk("abort_collect_in_ready", 72'(in_ready), 72'(0));
    repeat (10) @(negedge clk);
    chk("abort_collect_writes", 72'(w_falls - f0), 72'(1));

    // start and abort together in IDLE: abort wins.
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 72'(busy), 72'(0));
    chk("start_abort_in_ready", 72'(in_ready), 72'(0));

    // Abort during WLOW: the word completes, then the loader returns to idle.
    f0 = w_falls;
    start_load();
    send_bytes(8'd0, 64'hC0DE_CAFE_1234_5678, 8, 0);
    wait_w_low();
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("abort_wlow_done", 72'(done), 72'(0));
    chk("abort_wlow_in_ready", 72'(in_ready), 72'(0));
    chk("abort_wlow_writes", 72'(w_falls - f0), 72'(1));
    chk("abort_wlow_mem0", 72'(mem[0]), 72'(64'hC0DE_CAFE_1234_5678));

    // Reset in the second WLOW cycle: strobes release immediately.
    start_load();
    send_bytes(8'd0, 64'h7777_6666_5555_4444, 8, 0);
    wait_w_low();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_w", 72'(w_n), 72'(1));
    chk("midrst_cs", 72'(cs_n), 72'(1));
    chk("midrst_oe", 72'(oe_n), 72'(1));
    chk("midrst_addr", 72'(addr), 72'(0));
    chk("midrst_wdata", 72'(wdata), 72'(0));
    chk("midrst_in_ready", 72'(in_ready), 72'(0));
    chk("midrst_busy", 72'(busy), 72'(0));
    chk("midrst_done", 72'(done), 72'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_load({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b0, 8'd0);

`ifdef MICROCODE_LOADER_VERIFY_EN
    corrupt = 1'b1;
    run_load({$urandom, $urandom}, {$urandom, $urandom}, 0, 1'b0, 1'b1, 8'd1);
    corrupt = 1'b0;
    run_load({$urandom, $urandom}, {$urandom, $urandom}, 2, 1'b0, 1'b0, 8'd0);
`endif

    // Randomized loads, some with a stray start while busy.
    for (int it = 0; it < 8; it++) begin
      run_load({$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'b0, 8'd0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 72'(exp_q.size()), 72'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
